// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the register file write port between two
// writeback requesters (req0 = ALU, req1 = load/memory). Each requester owns
// a one-entry holding buffer; one buffer is drained per cycle into registered
// outputs that drive the register file write port directly.
// Build option: define WR_ARB_RR_EN for round-robin arbitration between full
// buffers; without it req0 has fixed priority and req1 may starve.
module reg_write_arbiter #(
  parameter int N      = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [N-1:0]      req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [N-1:0]      req1_data,
  output logic              Reg_write_out,
  output logic [ADDR_W-1:0] Write_Register_out,
  output logic [N-1:0]      Write_Data_out,
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic              idle
);

  // Per-requester views, indexed 0/1 so both buffers share one generate body.
  logic [1:0]        w_req_valid;
  logic [ADDR_W-1:0] w_req_addr [2];
  logic [N-1:0]      w_req_data [2];

  logic [1:0]        w_buf_valid;
  logic [ADDR_W-1:0] w_buf_addr [2];
  logic [N-1:0]      w_buf_data [2];

  logic [1:0]        w_grant;
  logic [1:0]        w_ready;
  logic [1:0]        w_accept;
  logic              w_any_grant;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [N-1:0]      w_sel_data;

  // Registered output stage
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [N-1:0]      r_wr_data;
  logic [CNT_W-1:0]  r_conflict_cnt;

  assign w_req_valid   = {req1_valid, req0_valid};
  assign w_req_addr[0] = req0_addr;
  assign w_req_addr[1] = req1_addr;
  assign w_req_data[0] = req0_data;
  assign w_req_data[1] = req1_data;

  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];

  // ---------------------------------------------------------------------------
  // Holding buffers, one per requester
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      logic              r_valid;
      logic [ADDR_W-1:0] r_addr;
      logic [N-1:0]      r_data;

      // A slot being drained this cycle is free again at the same edge, so a
      // saturating requester does not lose a cycle behind its own grant.
      assign w_ready[gi]  = reset & (~r_valid | w_grant[gi]);
      assign w_accept[gi] = w_req_valid[gi] & w_ready[gi];

      assign w_buf_valid[gi] = r_valid;
      assign w_buf_addr[gi]  = r_addr;
      assign w_buf_data[gi]  = r_data;

      // Capture an accepted entry; otherwise release the slot once granted.
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_valid <= 1'b0;
          r_addr  <= '0;
          r_data  <= '0;
        end else if (w_accept[gi]) begin
          r_valid <= 1'b1;
          r_addr  <= w_req_addr[gi];
          r_data  <= w_req_data[gi];
        end else if (w_grant[gi]) begin
          r_valid <= 1'b0;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef WR_ARB_RR_EN
  // Index of the most recent winner; starts at 1 so req0 wins the first tie.
  logic r_last;

  // Remember which buffer was drained last to alternate on ties.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last <= 1'b1;
    end else if (w_grant[0]) begin
      r_last <= 1'b0;
    end else if (w_grant[1]) begin
      r_last <= 1'b1;
    end
  end

  // A lone full buffer always wins; on a tie the one that did not win last.
  always_comb begin
    w_grant = w_buf_valid;
    if (w_buf_valid == 2'b11) begin
      w_grant = r_last ? 2'b01 : 2'b10;
    end
  end
`else
  // A lone full buffer always wins; on a tie req0 has priority.
  always_comb begin
    w_grant = w_buf_valid;
    if (w_buf_valid == 2'b11) begin
      w_grant = 2'b01;
    end
  end
`endif

  assign w_any_grant = |w_grant;
  assign w_sel_addr  = w_grant[1] ? w_buf_addr[1] : w_buf_addr[0];
  assign w_sel_data  = w_grant[1] ? w_buf_data[1] : w_buf_data[0];

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  // Register the granted entry; writes to register 0 retire without enabling
  // the register file, and address/data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_reg_write <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else if (w_any_grant) begin
      r_reg_write <= (w_sel_addr != '0);
      r_wr_addr   <= w_sel_addr;
      r_wr_data   <= w_sel_data;
    end else begin
      r_reg_write <= 1'b0;
    end
  end

  // Count cycles with both buffers occupied, sticking at the maximum value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_conflict_cnt <= '0;
    end else if ((&w_buf_valid) && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
    end
  end

  assign Reg_write_out      = r_reg_write;
  assign Write_Register_out = r_wr_addr;
  assign Write_Data_out     = r_wr_data;
  assign conflict_cnt       = r_conflict_cnt;
  assign idle               = ~(|w_buf_valid) & ~r_reg_write;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed scenarios plus randomized traffic, checked
// cycle by cycle against a behavioural model of the two slots and the port.
module tb_reg_write_arbiter;
  localparam int N      = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;
`ifdef WR_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req0_valid = 1'b0;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr = '0;
  logic [N-1:0]      req0_data = '0;
  logic              req1_valid = 1'b0;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr = '0;
  logic [N-1:0]      req1_data = '0;
  logic              Reg_write_out;
  logic [ADDR_W-1:0] Write_Register_out;
  logic [N-1:0]      Write_Data_out;
  logic [CNT_W-1:0]  conflict_cnt;
  logic              idle;

  always #5 clk = ~clk;

  reg_write_arbiter #(.N(N), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .Reg_write_out(Reg_write_out), .Write_Register_out(Write_Register_out),
    .Write_Data_out(Write_Data_out), .conflict_cnt(conflict_cnt), .idle(idle)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Behavioural model: two slots, last winner, registered write port, counter.
  bit          m_v [2];
  logic [4:0]  m_a [2];
  logic [31:0] m_d [2];
  int          m_last = 1;
  bit          m_we = 0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;
  int unsigned m_cnt = 0;

  // Shadow register file fed from the DUT write port, plus a log of writes.
  logic [31:0] rf [32];
  int          wlog [$];

  typedef struct { logic [4:0] a; logic [31:0] d; } item_t;
  item_t q0 [$];
  item_t q1 [$];

  function automatic int m_winner();
    if (m_v[0] && m_v[1]) return RR ? ((m_last == 0) ? 1 : 0) : 0;
    if (m_v[0]) return 0;
    if (m_v[1]) return 1;
    return -1;
  endfunction

  // One clock: drive inputs, check readies, advance model, check outputs.
  task automatic do_cycle(input bit rst_n,
                          input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                          input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                          output bit rd0, output bit rd1);
    int w;
    bit mr [2];
    reset = rst_n;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    w = m_winner();
    for (int i = 0; i < 2; i++) mr[i] = rst_n && (!m_v[i] || w == i);
    rd0 = req0_ready;
    rd1 = req1_ready;
    check_val("req0_ready", req0_ready, mr[0]);
    check_val("req1_ready", req1_ready, mr[1]);
    @(posedge clk);
    if (!rst_n) begin
      m_v[0] = 0; m_v[1] = 0; m_last = 1;
      m_we = 0; m_wa = '0; m_wd = '0; m_cnt = 0;
    end else begin
      if (m_v[0] && m_v[1] && m_cnt < 65535) m_cnt++;
      if (w >= 0) begin
        m_we = (m_a[w] != 0); m_wa = m_a[w]; m_wd = m_d[w];
        m_last = w; m_v[w] = 0;
      end else begin
        m_we = 0;
      end
      if (v0 && mr[0]) begin m_v[0] = 1; m_a[0] = a0; m_d[0] = d0; end
      if (v1 && mr[1]) begin m_v[1] = 1; m_a[1] = a1; m_d[1] = d1; end
    end
    @(negedge clk);
    check_val("Reg_write_out", Reg_write_out, m_we);
    check_val("Write_Register_out", Write_Register_out, m_wa);
    check_val("Write_Data_out", Write_Data_out, m_wd);
    check_val("conflict_cnt", conflict_cnt, m_cnt);
    check_val("idle", idle, !m_v[0] && !m_v[1] && !m_we);
    if (Reg_write_out) begin
      rf[Write_Register_out] = Write_Data_out;
      wlog.push_back(int'(Write_Register_out));
      $display("write r%0d <= %08h", Write_Register_out, Write_Data_out);
    end
  endtask

  task automatic idle_cycle(input bit rst_n);
    bit r0, r1;
    do_cycle(rst_n, 0, '0, '0, 0, '0, '0, r0, r1);
  endtask

  // Present queued entries with valid/ready handshake until both drain.
  task automatic run_queues(input int extra);
    bit r0, r1, v0, v1;
    item_t i0, i1;
    int guard = 0;
    while ((q0.size() > 0 || q1.size() > 0) && guard < 60) begin
      v0 = q0.size() > 0; v1 = q1.size() > 0;
      i0 = '{a: '0, d: '0}; i1 = '{a: '0, d: '0};
      if (v0) i0 = q0[0];
      if (v1) i1 = q1[0];
      do_cycle(1, v0, i0.a, i0.d, v1, i1.a, i1.d, r0, r1);
      if (v0 && r0) void'(q0.pop_front());
      if (v1 && r1) void'(q1.pop_front());
      guard++;
    end
    check_val("queues_drained", q0.size() + q1.size(), 0);
    repeat (extra) idle_cycle(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r0, r1;
    int exp_order [6];
    for (int i = 0; i < 32; i++) rf[i] = '0;
    @(negedge clk);

    // Reset held low with req0 asserting valid: never ready, outputs zero.
    for (int c = 0; c < 3; c++) begin
      do_cycle(0, 1, 5'd7, 32'h11, 0, '0, '0, r0, r1);
      check_val("rst_req0_ready", r0, 0);
    end
    check_val("rst_we", Reg_write_out, 0);
    check_val("rst_addr", Write_Register_out, 0);
    check_val("rst_data", Write_Data_out, 0);
    check_val("rst_cnt", conflict_cnt, 0);
    check_val("rst_idle", idle, 1);
    do_cycle(1, 1, 5'd7, 32'h11, 0, '0, '0, r0, r1);
    check_val("first_accept_ready", r0, 1);
    check_val("first_accept_busy", idle, 0);
    repeat (3) idle_cycle(1);

    // Single uncontested write.
    wlog.delete();
    do_cycle(1, 1, 5'd2, 32'd15, 0, '0, '0, r0, r1);
    check_val("single_not_yet", Reg_write_out, 0);
    idle_cycle(1);
    check_val("single_we", Reg_write_out, 1);
    check_val("single_addr", Write_Register_out, 2);
    check_val("single_data", Write_Data_out, 15);
    idle_cycle(1);
    check_val("single_we_drop", Reg_write_out, 0);
    check_val("single_idle", idle, 1);

    // Both requesters saturating.
    idle_cycle(0);
    wlog.delete();
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{a: 5'(4 + i), d: 32'(100 + i)});
      q1.push_back('{a: 5'(25 + i), d: 32'(200 + i)});
    end
    run_queues(4);
    if (RR) exp_order = '{4, 25, 5, 26, 6, 27};
    else    exp_order = '{4, 5, 6, 25, 26, 27};
    check_val("order_len", wlog.size(), 6);
    for (int i = 0; i < 6 && i < wlog.size(); i++)
      check_val($sformatf("order_%0d", i), wlog[i], exp_order[i]);
    check_val("conflict_total", conflict_cnt, RR ? 5 : 3);

    // Write to register 0 retires silently.
    wlog.delete();
    q1.push_back('{a: 5'd0, d: 32'd76});
    run_queues(3);
    check_val("r0_no_write", wlog.size(), 0);
    check_val("r0_data_held", Write_Data_out, 76);
    check_val("r0_we", Reg_write_out, 0);

    // Same destination from both sides: later grant persists.
    idle_cycle(0);
    wlog.delete();
    q0.push_back('{a: 5'd31, d: 32'd8});
    q1.push_back('{a: 5'd31, d: 32'd21});
    run_queues(3);
    check_val("same_addr_writes", wlog.size(), 2);
    check_val("same_addr_readback", rf[31], 21);

    // Reset while both buffers are full discards them.
    wlog.delete();
    do_cycle(1, 1, 5'd9, 32'h99, 1, 5'd10, 32'haa, r0, r1);
    check_val("full_busy", idle, 0);
    idle_cycle(0);
    check_val("rst_full_we", Reg_write_out, 0);
    check_val("rst_full_idle", idle, 1);
    repeat (3) idle_cycle(1);
    check_val("rst_full_no_write", wlog.size(), 0);

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 400; c++) begin
      do_cycle($urandom_range(0, 39) != 0,
               $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
               $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
               r0, r1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
